// File: rtl/imm_encoder_pkg.sv
// Shared constants for the immediate encoder: format codes (same as the extender),
// instruction field positions and the packed stage payload.
package imm_encoder_pkg;

  localparam logic [2:0] I_TYPE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] B_TYPE = 3'd2;
  localparam logic [2:0] J_TYPE = 3'd3;
  localparam logic [2:0] U_TYPE = 3'd4;

  localparam int I_HI    = 31, I_LO    = 20;
  localparam int S_HI_HI = 31, S_HI_LO = 25;
  localparam int S_LO_HI = 11, S_LO_LO = 7;
  localparam int B_SIGN  = 31, B_B11   = 7;
  localparam int B_MID_HI = 30, B_MID_LO = 25;
  localparam int B_LO_HI  = 11, B_LO_LO  = 8;
  localparam int J_SIGN  = 31, J_B11   = 20;
  localparam int J_MID_HI = 30, J_MID_LO = 21;
  localparam int J_HI_HI  = 19, J_HI_LO  = 12;
  localparam int U_HI    = 31, U_LO    = 12;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_t;

  // True when v is the sign extension of its low nbits bits.
  function automatic logic fits_signed(input logic [31:0] v, input int nbits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (nbits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Input/output beat handshake of the immediate encoder.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_imm_src;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (output in_valid, in_imm_src, in_imm, in_base, out_ready,
                  input  in_ready, out_valid, out_instr, out_err);
  modport slave  (input  in_valid, in_imm_src, in_imm, in_base, out_ready,
                  output in_ready, out_valid, out_instr, out_err);
endinterface

// File: rtl/imm_extend.sv
// Immediate extender (decode side), used only by the round-trip self-check
// enabled with IMM_ENC_ROUNDTRIP_CHECK_EN.
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
module imm_extend (
  input  logic [2:0]  imm_src,
  input  logic [31:0] instr,
  output logic [31:0] imm_ext
);
  always_comb begin
    imm_ext = '0;
    case (imm_src)
      3'd0: imm_ext = {{20{instr[31]}}, instr[31:20]};
      3'd1: imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'd2: imm_ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'd3: imm_ext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      3'd4: imm_ext = {instr[31:12], 12'b0};
      default: imm_ext = '0;
    endcase
  end
endmodule
`endif

// File: rtl/imm_pack.sv
// Combinational encode: scatter imm into the format's instruction fields over base,
// and flag out-of-range / misaligned immediates when STRICT.
module imm_pack
  import imm_encoder_pkg::*;
#(
  parameter int STRICT = 1
) (
  input  logic [2:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output enc_t        enc
);

  logic [31:0] instr;
  logic        rng_err;
  logic        src_bad;

  always_comb begin
    instr   = base;
    rng_err = 1'b0;
    src_bad = 1'b0;
    case (imm_src)
      I_TYPE: begin
        instr[I_HI:I_LO] = imm[11:0];
        rng_err = !fits_signed(imm, 12);
      end
      S_TYPE: begin
        instr[S_HI_HI:S_HI_LO] = imm[11:5];
        instr[S_LO_HI:S_LO_LO] = imm[4:0];
        rng_err = !fits_signed(imm, 12);
      end
      B_TYPE: begin
        instr[B_SIGN]            = imm[12];
        instr[B_B11]             = imm[11];
        instr[B_MID_HI:B_MID_LO] = imm[10:5];
        instr[B_LO_HI:B_LO_LO]   = imm[4:1];
        rng_err = !fits_signed(imm, 13) || imm[0];
      end
      J_TYPE: begin
        instr[J_SIGN]            = imm[20];
        instr[J_MID_HI:J_MID_LO] = imm[10:1];
        instr[J_B11]             = imm[11];
        instr[J_HI_HI:J_HI_LO]   = imm[19:12];
        rng_err = !fits_signed(imm, 21) || imm[0];
      end
      U_TYPE: begin
        instr[U_HI:U_LO] = imm[31:12];
        rng_err = |imm[11:0];
      end
      default: src_bad = 1'b1;
    endcase
    enc.instr = instr;
    // Unknown formats are always errors; range faults only count when checking.
    enc.err   = src_bad || ((STRICT != 0) && rng_err);
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder with saturating error counter.
// Optional round-trip self-check under IMM_ENC_ROUNDTRIP_CHECK_EN.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int STRICT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_encoder_if.slave     bus,
  output logic [CNT_W-1:0] err_count,
  output logic             rt_mismatch
);

  localparam int STAGES = 2;

  logic [STAGES:1]  vld_pipe_q, vld_pipe_d;
  enc_t             s1_q, s1_d, s2_q, s2_d, enc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s2_load, s1_adv;

  imm_pack #(.STRICT(STRICT)) u_pack (
    .imm_src (bus.in_imm_src),
    .imm     (bus.in_imm),
    .base    (bus.in_base),
    .enc     (enc)
  );

  always_comb begin
    s2_load    = !vld_pipe_q[2] || bus.out_ready;
    s1_adv     = s2_load || !vld_pipe_q[1];
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    cnt_d      = cnt_q;
    if (s1_adv) begin
      vld_pipe_d[1] = bus.in_valid;
      if (bus.in_valid) s1_d = enc;
    end
    if (s2_load) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) s2_d = s1_q;
    end
    if (vld_pipe_q[2] && bus.out_ready && s2_q.err && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = vld_pipe_q[2];
  assign bus.out_instr = s2_q.instr;
  assign bus.out_err   = s2_q.err;
  assign err_count     = cnt_q;

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
  logic [2:0]  s1_src_q, s1_src_d;
  logic [31:0] s1_imm_q, s1_imm_d, rt_ext;
  logic        rt_q, rt_d;

  imm_extend u_ext (
    .imm_src (s1_src_q),
    .instr   (s1_q.instr),
    .imm_ext (rt_ext)
  );

  // Decode the S1 word back and compare with the immediate it was built from.
  always_comb begin
    s1_src_d = s1_src_q;
    s1_imm_d = s1_imm_q;
    if (s1_adv && bus.in_valid) begin
      s1_src_d = bus.in_imm_src;
      s1_imm_d = bus.in_imm;
    end
    rt_d = rt_q || (vld_pipe_q[1] && !s1_q.err && (s1_src_q <= U_TYPE) &&
                    (rt_ext != s1_imm_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_src_q <= '0;
      s1_imm_q <= '0;
      rt_q     <= 1'b0;
    end else begin
      s1_src_q <= s1_src_d;
      s1_imm_q <= s1_imm_d;
      rt_q     <= rt_d;
    end
  end

  assign rt_mismatch = rt_q;
`else
  assign rt_mismatch = 1'b0;
`endif

endmodule
